// File: rtl/inertial_filter_pkg.sv
// Shared types and helpers for the inertial_filter block.
package inertial_filter_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } if_state_t;

  // Counter width able to hold 0..delay.
  function automatic int unsigned cnt_width(input int unsigned delay);
    return (delay < 1) ? 1 : $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/inertial_filter_sync_chain.sv
// Input synchronizer: din shifts through STAGES flops; q is the last stage.
module sync_chain #(
  parameter int unsigned STAGES = 2,
  parameter logic        INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {STAGES{INIT}};
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/inertial_filter.sv
// Clocked inertial delay: a synchronized level must persist DELAY cycles
// before dout follows; shorter excursions are swallowed and flagged as glitches.
module inertial_filter
  import inertial_filter_pkg::*;
#(
  parameter int unsigned DELAY       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic glitch,
  output logic busy
);

  localparam int unsigned     CNT_W    = cnt_width(DELAY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY - 1);

  logic             s;
  if_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dout_nxt, rise_nxt, fall_nxt, glitch_nxt;
  logic             differs;

  sync_chain #(
    .STAGES (SYNC_STAGES),
    .INIT   (INIT)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= STABLE;
      cnt    <= '0;
      dout   <= INIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dout   <= dout_nxt;
      rise   <= rise_nxt;
      fall   <= fall_nxt;
      glitch <= glitch_nxt;
    end
  end

  assign differs = (s != dout);

  // Next-state: count consecutive disagreeing cycles, commit on the DELAY-th.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dout_nxt   = dout;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    glitch_nxt = 1'b0;
    case (state)
      STABLE: begin
        if (differs) begin
          if (DELAY == 1) begin
            dout_nxt = s;
            rise_nxt = s;
            fall_nxt = ~s;
          end else begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = PENDING;
          end
        end
      end
      PENDING: begin
        if (differs) begin
          if (cnt == CNT_LAST) begin
            dout_nxt  = s;
            rise_nxt  = s;
            fall_nxt  = ~s;
            cnt_nxt   = '0;
            state_nxt = STABLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          cnt_nxt    = '0;
          glitch_nxt = 1'b1;
          state_nxt  = STABLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = STABLE;
      end
    endcase
  end

  assign busy = (state == PENDING);

endmodule

// File: tb/tb_inertial_filter.sv
// Randomized and directed bench for inertial_filter against a run-length reference model.
module tb_inertial_filter;

  localparam int unsigned DELAY = 5;
  localparam int unsigned SS    = 2;
  localparam logic        INIT  = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall, glitch, busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: queue of synchronizer contents (oldest first), run length.
  bit mq[$];
  bit m_dout;
  int m_run;
  bit m_rise, m_fall, m_glitch;

  int n_rise, n_fall, n_glitch, first_rise, first_fall, idx;

  inertial_filter #(
    .DELAY       (DELAY),
    .SYNC_STAGES (SS),
    .INIT        (INIT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .dout   (dout),
    .rise   (rise),
    .fall   (fall),
    .glitch (glitch),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit d, input bit r);
    bit s;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_glitch = 1'b0;
    if (r) begin
      mq.delete();
      repeat (SS) mq.push_back(INIT);
      m_dout = INIT;
      m_run  = 0;
    end else begin
      s = mq.pop_front();
      mq.push_back(d);
      if (s != m_dout) begin
        m_run++;
        if (m_run == int'(DELAY)) begin
          m_dout = s;
          m_rise = s;
          m_fall = ~s;
          m_run  = 0;
        end
      end else if (m_run > 0) begin
        m_glitch = 1'b1;
        m_run    = 0;
      end
    end
  endtask

  task automatic clear_stats();
    n_rise = 0; n_fall = 0; n_glitch = 0;
    first_rise = -1; first_fall = -1; idx = 0;
  endtask

  task automatic apply(input bit d, input bit r);
    @(negedge clk);
    din = d;
    rst = r;
    @(posedge clk);
    model_step(d, r);
    #1;
    check("dout",   32'(dout),   32'(m_dout));
    check("rise",   32'(rise),   32'(m_rise));
    check("fall",   32'(fall),   32'(m_fall));
    check("glitch", 32'(glitch), 32'(m_glitch));
    check("busy",   32'(busy),   32'(m_run > 0));
    if (rise === 1'b1) begin n_rise++; if (first_rise < 0) first_rise = idx; end
    if (fall === 1'b1) begin n_fall++; if (first_fall < 0) first_fall = idx; end
    if (glitch === 1'b1) n_glitch++;
    idx++;
  endtask

  initial begin
    bit lvl;
    int dwell;
    int dwells[6] = '{2, 3, 4, 5, 6, 7};
    repeat (SS) mq.push_back(INIT);
    m_dout = INIT;
    m_run  = 0;

    // Reset held with din high
    clear_stats();
    repeat (3) apply(1'b1, 1'b1);
    repeat (8) apply(1'b0, 1'b0);

    // Clean rise
    clear_stats();
    repeat (10) apply(1'b1, 1'b0);
    check("clean_rise_edge", 32'(first_rise), 32'd6);
    check("clean_rise_cnt",  32'(n_rise),     32'd1);
    clear_stats();
    repeat (12) apply(1'b0, 1'b0);
    check("clean_fall_cnt",  32'(n_fall),     32'd1);

    // Short pulse
    clear_stats();
    repeat (4) apply(1'b1, 1'b0);
    repeat (12) apply(1'b0, 1'b0);
    check("short_glitch", 32'(n_glitch), 32'd1);
    check("short_rise",   32'(n_rise),   32'd0);

    // Boundary pulse of exactly DELAY
    clear_stats();
    repeat (5) apply(1'b1, 1'b0);
    repeat (12) apply(1'b0, 1'b0);
    check("bound_rise_edge", 32'(first_rise), 32'd6);
    check("bound_fall_edge", 32'(first_fall), 32'd11);
    check("bound_glitch",    32'(n_glitch),   32'd0);

    // Z-pattern dwells
    clear_stats();
    lvl = 1'b1;
    foreach (dwells[k]) begin
      repeat (dwells[k]) apply(lvl, 1'b0);
      lvl = ~lvl;
    end
    repeat (12) apply(1'b0, 1'b0);
    check("z_glitch", 32'(n_glitch), 32'd2);
    check("z_rise",   32'(n_rise),   32'd1);
    check("z_fall",   32'(n_fall),   32'd1);

    // Toggle every cycle
    clear_stats();
    for (int i = 0; i < 12; i++) apply(bit'(i % 2), 1'b0);
    repeat (6) apply(1'b0, 1'b0);
    check("toggle_glitch", 32'(n_glitch), 32'd6);
    check("toggle_rise",   32'(n_rise),   32'd0);

    // Reset in the middle of a pending change
    clear_stats();
    repeat (4) apply(1'b1, 1'b0);
    apply(1'b1, 1'b1);
    repeat (10) apply(1'b1, 1'b0);
    check("midrst_rise_edge", 32'(first_rise), 32'd11);
    check("midrst_rise_cnt",  32'(n_rise),     32'd1);
    check("midrst_glitch",    32'(n_glitch),   32'd0);

    // Random dwells with occasional reset
    clear_stats();
    for (int n = 0; n < 120; n++) begin
      lvl   = bit'($urandom_range(0, 1));
      dwell = int'($urandom_range(1, 8));
      for (int j = 0; j < dwell; j++) begin
        apply(lvl, $urandom_range(0, 49) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
